mem_access_stage: RTL

MEM-stage load/store unit that consumes the EX/MEM pipeline register outputs and produces the MEM/WB register contents. It resolves conditional branches and handles byte/half/word/double loads and stores against a 64-bit data memory over a req/ack handshake. While an access is outstanding it stalls the front of the pipeline. It sits between the EX/MEM register and the MEM/WB register and owns the only data-memory port.

---
 rtl/mem_access_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: resolves branches, runs sized loads/stores over a
// req/ack data-memory port, stalls the front end while busy, and owns MEM/WB.
module mem_access_stage #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    rd_in,
  input  logic          Branch_in,
  input  logic          MemWrite_in,
  input  logic          MemRead_in,
  input  logic          MemtoReg_in,
  input  logic          RegWrite_in,
  input  logic [DW-1:0] Adder_B_in,
  input  logic [DW-1:0] Result_in,
  input  logic          ZERO_in,
  input  logic          pos_in,
  input  logic [DW-1:0] data_in,
  input  logic [2:0]    funct3_in,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [7:0]    mem_wstrb,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall,
  output logic          branch_taken,
  output logic [DW-1:0] branch_target,
  output logic [4:0]    wb_rd,
  output logic          wb_RegWrite,
  output logic          wb_MemtoReg,
  output logic [DW-1:0] wb_ReadData,
  output logic [DW-1:0] wb_Result,
  output logic          misalign_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic          acc, mis, issue, bad, done;
  logic [DW-1:0] ld_data;

  function automatic logic misaligned_f(input logic [1:0] size, input logic [2:0] lane);
    case (size)
      2'b01:   misaligned_f = lane[0];
      2'b10:   misaligned_f = |lane[1:0];
      2'b11:   misaligned_f = |lane;
      default: misaligned_f = 1'b0;
    endcase
  endfunction

  function automatic logic [DW-1:0] load_fmt(input logic [2:0] f3, input logic [2:0] lane,
                                             input logic [DW-1:0] rdata);
    logic [DW-1:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (f3)
      3'b000:  load_fmt = {{(DW-8){sh[7]}}, sh[7:0]};
      3'b001:  load_fmt = {{(DW-16){sh[15]}}, sh[15:0]};
      3'b010:  load_fmt = {{(DW-32){sh[31]}}, sh[31:0]};
      3'b100:  load_fmt = {{(DW-8){1'b0}}, sh[7:0]};
      3'b101:  load_fmt = {{(DW-16){1'b0}}, sh[15:0]};
      3'b110:  load_fmt = {{(DW-32){1'b0}}, sh[31:0]};
      default: load_fmt = rdata;
    endcase
  endfunction

  // Replicating the datum across the word puts it on every lane it could target.
  function automatic logic [DW-1:0] store_data(input logic [1:0] size, input logic [DW-1:0] d);
    case (size)
      2'b00:   store_data = {(DW/8){d[7:0]}};
      2'b01:   store_data = {(DW/16){d[15:0]}};
      2'b10:   store_data = {(DW/32){d[31:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [7:0] store_strb(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] m;
    case (size)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    store_strb = m << lane;
  endfunction

  assign acc           = MemRead_in | MemWrite_in;
  assign mis           = misaligned_f(funct3_in[1:0], Result_in[2:0]);
  assign issue         = (state == IDLE) & acc & ~mis;
  assign bad           = (state == IDLE) & acc & mis;
  assign done          = (state == BUSY) & mem_ack;
  assign stall         = issue | ((state == BUSY) & ~mem_ack);
  assign branch_taken  = (state == IDLE) & Branch_in & (ZERO_in ~^ pos_in);
  assign branch_target = Adder_B_in;
  assign ld_data       = (done & MemRead_in) ? load_fmt(funct3_in, Result_in[2:0], mem_rdata) : '0;

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (issue) state_nxt = BUSY;
    end else begin
      if (mem_ack) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Memory port registers: captured on issue, held while the access is outstanding
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (issue) begin
      mem_req   <= 1'b1;
      mem_we    <= MemWrite_in;
      mem_addr  <= {Result_in[DW-1:3], 3'b000};
      mem_wdata <= store_data(funct3_in[1:0], data_in);
      mem_wstrb <= MemWrite_in ? store_strb(funct3_in[1:0], Result_in[2:0]) : 8'h00;
    end else if (done) begin
      mem_req   <= 1'b0;
    end
  end

  // MEM/WB register: a stalled or misaligned instruction leaves a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_rd        <= '0;
      wb_RegWrite  <= 1'b0;
      wb_MemtoReg  <= 1'b0;
      wb_ReadData  <= '0;
      wb_Result    <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= bad;
      if (!stall) begin
        wb_rd       <= rd_in;
        wb_RegWrite <= RegWrite_in & ~bad;
        wb_MemtoReg <= MemtoReg_in & ~bad;
        wb_ReadData <= ld_data;
        wb_Result   <= Result_in;
      end else begin
        wb_RegWrite <= 1'b0;
        wb_MemtoReg <= 1'b0;
      end
    end
  end

endmodule
